// File: rtl/riscv_core_if.sv
// ============================================================================
// riscv_core_if : RISC-V instruction-fetch stage (PC, icache fetch, skid, redirect)
// Revision 1.0
// ============================================================================
`default_nettype none

module riscv_core_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        if_ic_req,
  output logic [31:0] if_ic_addr,
  input  logic        ic_if_ack,
  input  logic [31:0] icache_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  input  logic [1:0]  id_if_mux_cntl,
  input  logic [5:0]  id_if_branch,
  input  logic [31:0] id_if_target,
  input  logic        stall_back,
  output logic        if_exc_misaligned
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        exc_q, exc_d;

  logic        w_redir;
  logic [31:0] w_tgt_al;

  assign w_redir  = (id_if_mux_cntl == 2'b01) |
                    ((id_if_mux_cntl == 2'b10) & (|id_if_branch));
  assign w_tgt_al = {id_if_target[31:2], 2'b00};
  assign exc_d    = w_redir & (|id_if_target[1:0]);

  assign if_exc_misaligned = exc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if_ic_req    = 1'b0;
    if_ic_addr   = pc_q;
    if_id_valid  = 1'b0;
    if_id_instr  = 32'h0;
    if_id_pc     = pc_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (w_redir) pc_d = w_tgt_al;
      end

      REQ: begin
        if_ic_req = 1'b1;
        if (ic_if_ack) begin
          if_id_instr = icache_rdata;
          if (w_redir) begin
            pc_d = w_tgt_al;
          end else begin
            if_id_valid = 1'b1;
            pc_d        = pc_q + 32'd4;
            if (stall_back) begin
              skid_instr_d = icache_rdata;
              skid_pc_d    = pc_q;
              state_d      = HOLD;
            end
          end
        end else if (w_redir) begin
          // Request is outstanding: keep the address stable and discard its data.
          tgt_d   = w_tgt_al;
          state_d = DRAIN;
        end
      end

      HOLD: begin
        if_id_instr = skid_instr_q;
        if_id_pc    = skid_pc_q;
        if (w_redir) begin
          pc_d    = w_tgt_al;
          state_d = REQ;
        end else begin
          if_id_valid = 1'b1;
          if (!stall_back) state_d = REQ;
        end
      end

      DRAIN: begin
        if_ic_req = 1'b1;
        if (w_redir) tgt_d = w_tgt_al;
        if (ic_if_ack) begin
          pc_d    = w_redir ? w_tgt_al : tgt_q;
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      tgt_q        <= RESET_PC;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= RESET_PC;
      exc_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      exc_q        <= exc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_core_if.sv
// ============================================================================
// tb_riscv_core_if : directed table-driven bench for riscv_core_if
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_riscv_core_if;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0100;

  logic        clk;
  logic        rstn;
  logic        if_ic_req;
  logic [31:0] if_ic_addr;
  logic        ic_if_ack;
  logic [31:0] icache_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic [1:0]  id_if_mux_cntl;
  logic [5:0]  id_if_branch;
  logic [31:0] id_if_target;
  logic        stall_back;
  logic        if_exc_misaligned;

  riscv_core_if #(.RESET_PC(C_RESET_PC)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .if_ic_req         (if_ic_req),
    .if_ic_addr        (if_ic_addr),
    .ic_if_ack         (ic_if_ack),
    .icache_rdata      (icache_rdata),
    .if_id_instr       (if_id_instr),
    .if_id_pc          (if_id_pc),
    .if_id_valid       (if_id_valid),
    .id_if_mux_cntl    (id_if_mux_cntl),
    .id_if_branch      (id_if_branch),
    .id_if_target      (id_if_target),
    .stall_back        (stall_back),
    .if_exc_misaligned (if_exc_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic [1:0]  mux;
    logic [5:0]  br;
    logic [31:0] tgt;
    logic        stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_exc;
    logic        chk_data;
  } vec_t;

  vec_t vq[$];
  int   n_pass;
  int   n_total;

  task automatic add(input logic rst, input logic ack, input logic [31:0] rdata,
                     input logic [1:0] mux, input logic [5:0] br, input logic [31:0] tgt,
                     input logic stall, input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_instr,
                     input logic e_exc, input logic chk_data);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.mux = mux; v.br = br; v.tgt = tgt;
    v.stall = stall; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_exc = e_exc; v.chk_data = chk_data;
    vq.push_back(v);
  endtask

  task automatic check(input int idx, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL v%0d %s: got %h want %h", idx, name, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input vec_t v);
    rstn           = v.rst;
    ic_if_ack      = v.ack;
    icache_rdata   = v.rdata;
    id_if_mux_cntl = v.mux;
    id_if_branch   = v.br;
    id_if_target   = v.tgt;
    stall_back     = v.stall;
  endtask

  initial begin
    vec_t v;
    n_pass  = 0;
    n_total = 0;

    //    rst ack rdata          mux    br       tgt           stl req addr          vld pc            instr          exc chk
    add(0, 1, 32'hDEAD_BEEF, 2'b00, 6'd0,     32'h0,        0, 0, 32'h0000_0100, 0, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'h0000_0113, 2'b00, 6'd0,     32'h0,        0, 1, 32'h0000_0100, 1, 32'h0000_0100, 32'h0000_0113, 0, 1);
    add(0, 1, 32'h0040_0193, 2'b00, 6'd0,     32'h0,        1, 1, 32'h0000_0104, 1, 32'h0000_0104, 32'h0040_0193, 0, 1);
    add(0, 0, 32'hDEAD_BEEF, 2'b00, 6'd0,     32'h0,        1, 0, 32'h0000_0108, 1, 32'h0000_0104, 32'h0040_0193, 0, 1);
    add(0, 0, 32'hDEAD_BEEF, 2'b00, 6'd0,     32'h0,        1, 0, 32'h0000_0108, 1, 32'h0000_0104, 32'h0040_0193, 0, 1);
    add(0, 0, 32'hDEAD_BEEF, 2'b00, 6'd0,     32'h0,        0, 0, 32'h0000_0108, 1, 32'h0000_0104, 32'h0040_0193, 0, 1);
    // jump while 0x108 is outstanding, ack two cycles later
    add(0, 0, 32'hDEAD_BEEF, 2'b01, 6'd0,     32'h0000_2000, 0, 1, 32'h0000_0108, 0, 32'h0,        32'h0,        0, 0);
    add(0, 0, 32'hDEAD_BEEF, 2'b00, 6'd0,     32'h0,        0, 1, 32'h0000_0108, 0, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'hBAD0_0108, 2'b00, 6'd0,     32'h0,        0, 1, 32'h0000_0108, 0, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'h00A0_0093, 2'b10, 6'd0,     32'h0000_0040, 0, 1, 32'h0000_2000, 1, 32'h0000_2000, 32'h00A0_0093, 0, 1);
    add(0, 1, 32'hDEAD_BEEF, 2'b10, 6'b000100, 32'h0000_0040, 0, 1, 32'h0000_2004, 0, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'hDEAD_BEEF, 2'b01, 6'd0,     32'h0000_2002, 0, 1, 32'h0000_0040, 0, 32'h0,        32'h0,        0, 0);
    add(0, 0, 32'hDEAD_BEEF, 2'b00, 6'd0,     32'h0,        0, 1, 32'h0000_2000, 0, 32'h0,        32'h0,        1, 0);
    add(0, 1, 32'h1111_1111, 2'b00, 6'd0,     32'h0,        0, 1, 32'h0000_2000, 1, 32'h0000_2000, 32'h1111_1111, 0, 1);
    add(0, 1, 32'h2222_2222, 2'b11, 6'h3F,    32'h0000_0500, 0, 1, 32'h0000_2004, 1, 32'h0000_2004, 32'h2222_2222, 0, 1);
    // redirect twice during drain: newest target wins
    add(0, 0, 32'hDEAD_BEEF, 2'b01, 6'd0,     32'h0000_0300, 0, 1, 32'h0000_2008, 0, 32'h0,        32'h0,        0, 0);
    add(0, 0, 32'hDEAD_BEEF, 2'b10, 6'b000001, 32'h0000_0600, 0, 1, 32'h0000_2008, 0, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'hDEAD_BEEF, 2'b00, 6'd0,     32'h0,        0, 1, 32'h0000_2008, 0, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'h3333_3333, 2'b00, 6'd0,     32'h0,        1, 1, 32'h0000_0600, 1, 32'h0000_0600, 32'h3333_3333, 0, 1);
    add(0, 0, 32'hDEAD_BEEF, 2'b01, 6'd0,     32'h0000_0800, 1, 0, 32'h0000_0604, 0, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'h4444_4444, 2'b00, 6'd0,     32'h0,        0, 1, 32'h0000_0800, 1, 32'h0000_0800, 32'h4444_4444, 0, 1);
    // PC wrap at the top of the address space
    add(0, 1, 32'hDEAD_BEEF, 2'b01, 6'd0,     32'hFFFF_FFFC, 0, 1, 32'h0000_0804, 0, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'h5555_5555, 2'b00, 6'd0,     32'h0,        0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h5555_5555, 0, 1);
    add(0, 0, 32'hDEAD_BEEF, 2'b00, 6'd0,     32'h0,        1, 1, 32'h0000_0000, 0, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'h6666_6666, 2'b00, 6'd0,     32'h0,        1, 1, 32'h0000_0000, 1, 32'h0000_0000, 32'h6666_6666, 0, 1);
    // reset asserted while holding
    add(1, 0, 32'hDEAD_BEEF, 2'b00, 6'd0,     32'h0,        1, 0, 32'h0000_0004, 1, 32'h0000_0000, 32'h6666_6666, 0, 1);
    add(1, 1, 32'hDEAD_BEEF, 2'b00, 6'd0,     32'h0,        1, 0, 32'h0000_0100, 0, 32'h0000_0100, 32'h0,        0, 1);
    add(0, 1, 32'hDEAD_BEEF, 2'b00, 6'd0,     32'h0,        0, 0, 32'h0000_0100, 0, 32'h0,        32'h0,        0, 0);
    add(0, 0, 32'hDEAD_BEEF, 2'b00, 6'd0,     32'h0,        0, 1, 32'h0000_0100, 0, 32'h0,        32'h0,        0, 0);

    // Initial reset, then check the reset-state outputs while reset is still held
    rstn = 1'b1; ic_if_ack = 1'b0; icache_rdata = 32'h0; id_if_mux_cntl = 2'b00;
    id_if_branch = 6'd0; id_if_target = 32'h0; stall_back = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check(-1, "rst_req",   {31'h0, if_ic_req},         32'h0);
    check(-1, "rst_addr",  if_ic_addr,                  C_RESET_PC);
    check(-1, "rst_valid", {31'h0, if_id_valid},        32'h0);
    check(-1, "rst_pc",    if_id_pc,                    C_RESET_PC);
    check(-1, "rst_instr", if_id_instr,                 32'h0);
    check(-1, "rst_exc",   {31'h0, if_exc_misaligned},  32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(negedge clk);
      drive(v);
      #1;
      check(i, "req",   {31'h0, if_ic_req},        {31'h0, v.e_req});
      check(i, "addr",  if_ic_addr,                 v.e_addr);
      check(i, "valid", {31'h0, if_id_valid},       {31'h0, v.e_valid});
      check(i, "exc",   {31'h0, if_exc_misaligned}, {31'h0, v.e_exc});
      if (v.chk_data) begin
        check(i, "pc",    if_id_pc,    v.e_pc);
        check(i, "instr", if_id_instr, v.e_instr);
      end
    end

    // Ack delayed a variable number of cycles: address and request must stay put
    for (int d = 1; d <= 3; d++) begin
      logic [31:0] exp_addr;
      exp_addr = C_RESET_PC + 32'(d - 1) * 32'd4;
      for (int c = 0; c < d; c++) begin
        @(negedge clk);
        rstn = 1'b0; ic_if_ack = 1'b0; id_if_mux_cntl = 2'b00; stall_back = 1'b1;
        #1;
        check(100 + d, "wait_addr",  if_ic_addr,            exp_addr);
        check(100 + d, "wait_valid", {31'h0, if_id_valid},  32'h0);
      end
      @(negedge clk);
      ic_if_ack = 1'b1; icache_rdata = 32'hC0DE_0000 | exp_addr; stall_back = 1'b0;
      #1;
      check(100 + d, "dly_valid", {31'h0, if_id_valid}, 32'h1);
      check(100 + d, "dly_pc",    if_id_pc,             exp_addr);
      check(100 + d, "dly_instr", if_id_instr,          32'hC0DE_0000 | exp_addr);
    end

    @(negedge clk);
    ic_if_ack = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_core_if.md
Name: riscv_core_if

Overview:
Instruction-fetch stage of the RISC-V core. It sits directly upstream of the decode stage. It owns the PC, issues one-outstanding-request fetches to the instruction cache, and presents each fetched word with its PC to decode. It applies jump and branch redirects from decode, and holds a fetched word in a skid buffer while decode stalls.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded by reset; bits [1:0] must be 0.

Ports:
clk  input  1  core clock, all state on rising edge
rstn  input  1  reset; synchronous, active-high (1 = reset asserted)
if_ic_req  output  1  fetch request to icache
if_ic_addr  output  32  fetch address; word aligned; stable while if_ic_req=1 and no ack
ic_if_ack  input  1  icache response; icache_rdata valid this cycle
icache_rdata  input  32  instruction word from icache
if_id_instr  output  32  instruction presented to decode
if_id_pc  output  32  PC of if_id_instr
if_id_valid  output  1  if_id_instr/if_id_pc valid
id_if_mux_cntl  input  2  next-PC select: 00 PC+4, 01 jump (unconditional), 10 branch, 11 treated as 00
id_if_branch  input  6  branch outcome; any bit set = taken (used only when mux_cntl=10)
id_if_target  input  32  redirect target
stall_back  input  1  decode cannot accept this cycle
if_exc_misaligned  output  1  one-cycle pulse: redirect target had [1:0]!=0

Behaviour:
- Redirect condition: redir = (mux_cntl==01) | (mux_cntl==10 & |id_if_branch). Target used = {id_if_target[31:2],2'b00}. If id_if_target[1:0]!=0, if_exc_misaligned=1 in the next cycle.
- Reset (rstn=1 at clk edge), regardless of state:
  - pc_q=RESET_PC, state=IDLE.
  - if_ic_req=0, if_ic_addr=RESET_PC, if_id_valid=0, if_id_pc=RESET_PC, if_id_instr=0, if_exc_misaligned=0, skid buffer cleared.
  - Any in-flight request is abandoned; an ack arriving in the first post-reset cycle is ignored.
- States:
  - IDLE: req=0. The first cycle after reset release goes to REQ.
  - REQ: req=1, addr=pc_q.
  - HOLD: req=0; presents the skid buffer.
  - DRAIN: req=1 at the stale address; the response is discarded.
- REQ, ack, no redirect:
  - if_id_valid=1, if_id_instr=icache_rdata, if_id_pc=pc_q, all combinational in the ack cycle.
  - If stall_back=0: pc_q<=pc_q+4 (wraps mod 2^32) and stay in REQ. A zero-wait cache therefore gives 1 instruction/cycle.
  - If stall_back=1: capture the word and PC into the skid buffer, pc_q<=pc_q+4, go to HOLD.
- REQ, no ack: hold addr/req. stall_back has no effect.
- HOLD:
  - if_id_valid=1 from the buffer.
  - When stall_back=0, the word is consumed that cycle; go to REQ next cycle.
- Redirect arriving in REQ with ack, or in IDLE/HOLD:
  - pc_q<=target, go to REQ; the skid buffer is invalidated.
  - if_id_valid for the ack/buffer word is forced 0 in that cycle.
- Redirect arriving in REQ without ack:
  - Latch the target and go to DRAIN. Keep req/addr unchanged until ack.
  - The ack cycle gives if_id_valid=0; then pc_q<=latched target and go to REQ.
- Redirect in DRAIN: the latched target is overwritten; the newest redirect wins.
- Priority: reset > redirect > stall > sequential.
- if_id_valid is never 1 in DRAIN or IDLE.
- Address stability: if_ic_addr changes only in a cycle after ack, redirect-from-non-outstanding, or reset.

Test Plan:
- Reset release, RESET_PC=0x100, zero-wait ack every cycle, no stalls -> if_ic_addr 0x100,0x104,0x108 on consecutive cycles; if_id_pc follows the same sequence with if_id_valid=1 each ack cycle.
- Ack with stall_back=1 for 3 cycles at PC 0x104 -> if_id_valid=1 and if_id_pc=0x104 held for 4 cycles (ack cycle + HOLD); if_ic_req=0 during HOLD; the next request after release is 0x108.
- mux_cntl=01, target=0x2000, issued while a request to 0x108 is pending with ack delayed 2 cycles -> addr holds 0x108 until ack; that response gives valid=0; the next request is 0x2000 with no instruction from 0x108 delivered.
- mux_cntl=10 with id_if_branch=0 -> sequential PC+4. Same with id_if_branch=6'b000100, target=0x40 -> redirect to 0x40.
- Target 0x2002 -> fetch address 0x2000 and if_exc_misaligned pulses high for exactly 1 cycle.
- rstn asserted in HOLD with stall_back=1 -> next cycle if_id_valid=0 and if_ic_req=0; the cycle after release issues RESET_PC.
